multibeat_fetcher: RTL

Parametrised per-core instruction fetcher. It assembles an INSTR_WIDTH instruction from one or more MEM_DATA_WIDTH program-memory beats at consecutive addresses. A single-entry hit buffer lets a re-fetch of the last PC skip program memory, and a flush input invalidates that buffer. It sits between the core scheduler (core_state, current_pc) and the program-memory controller channel assigned to the core, and is the drop-in successor to the single-beat fetcher.

---
 rtl/multibeat_fetcher_if.sv | 25 ++
 rtl/multibeat_fetcher.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/multibeat_fetcher_if.sv
// multibeat_fetcher_if
//   Program-memory read channel between one core's fetcher and its
//   memory-controller port.
//   master (fetcher): drives mem_read_request / mem_read_address,
//                     samples mem_read_ready / mem_read_data.
//   slave  (memory) : the opposite directions.
interface multibeat_fetcher_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_read_request;
    logic [ADDR_W-1:0] mem_read_address;
    logic              mem_read_ready;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_read_request, mem_read_address,
        input  mem_read_ready, mem_read_data
    );

    modport slave (
        input  mem_read_request, mem_read_address,
        output mem_read_ready, mem_read_data
    );
endinterface

// File: rtl/multibeat_fetcher.sv
// multibeat_fetcher
//   Per-core instruction fetcher. Builds an INSTR_WIDTH instruction from
//   BEATS consecutive MEM_DATA_WIDTH program-memory beats. The last fetched
//   instruction and its PC form a single-entry hit buffer, so a re-fetch of
//   that PC completes in one cycle without touching memory.
// Ports
//   clk, reset_n    : clock, asynchronous active-low reset
//   core_state      : scheduler state (FETCH=3'b001, DECODE=3'b010)
//   current_pc      : PC to fetch, sampled only in IDLE
//   flush           : invalidates the hit buffer
//   mem             : program-memory read channel (master side)
//   fetcher_state   : IDLE=000, FETCHING=001, FETCHED=010
//   instruction     : last completed instruction (never partial)
//   fetch_hit       : one-cycle pulse on a buffer-hit IDLE->FETCHED
// All outputs are registered.
module multibeat_fetcher #(
    parameter int ADDR_WIDTH     = 8,
    parameter int INSTR_WIDTH    = 16,
    parameter int MEM_DATA_WIDTH = 16,
    parameter int HIT_BUFFER     = 1,
    localparam int BEATS          = INSTR_WIDTH / MEM_DATA_WIDTH,
    localparam int BEAT_W         = $clog2(BEATS),
    localparam int MEM_ADDR_WIDTH = ADDR_WIDTH + BEAT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2:0]             core_state,
    input  logic [ADDR_WIDTH-1:0]  current_pc,
    input  logic                   flush,
    multibeat_fetcher_if.master    mem,
    output logic [2:0]             fetcher_state,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   fetch_hit
);
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    localparam logic [2:0] FETCHER_IDLE     = 3'b000;
    localparam logic [2:0] FETCHER_FETCHING = 3'b001;
    localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

    // Counter is at least one bit wide so BEATS=1 still elaborates cleanly.
    localparam int              CNT_W    = (BEATS > 1) ? BEAT_W : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [2:0]                state_q, state_d;
    logic                      req_q, req_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
    logic [INSTR_WIDTH-1:0]    shadow_q, shadow_d;
    logic                      hit_q, hit_d;
    logic                      valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]     tag_q, tag_d;
    logic [ADDR_WIDTH-1:0]     pend_tag_q, pend_tag_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    // Sticky: a flush arrived during the current FETCHING sequence.
    logic                      flush_seen_q, flush_seen_d;

    logic                      is_hit;
    logic                      beat_ok;
    logic                      last_beat;
    logic [INSTR_WIDTH-1:0]    full_word;

    assign is_hit    = (HIT_BUFFER != 0) && valid_q && (tag_q == current_pc) && !flush;
    // ready only counts while a request is actually outstanding.
    assign beat_ok   = req_q && mem.mem_read_ready;
    assign last_beat = (cnt_q == LAST_BEAT);

    // Shadow with the incoming beat merged at its slot; on the final beat
    // this is the complete instruction.
    always_comb begin
        full_word = shadow_q;
        for (int k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k))
                full_word[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem.mem_read_data;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCHER_IDLE;
            req_q        <= 1'b0;
            addr_q       <= '0;
            instr_q      <= '0;
            shadow_q     <= '0;
            hit_q        <= 1'b0;
            valid_q      <= 1'b0;
            tag_q        <= '0;
            pend_tag_q   <= '0;
            cnt_q        <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            shadow_q     <= shadow_d;
            hit_q        <= hit_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            pend_tag_q   <= pend_tag_d;
            cnt_q        <= cnt_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCHER_IDLE: begin
                if (core_state == CORE_FETCH)
                    state_d = is_hit ? FETCHER_FETCHED : FETCHER_FETCHING;
            end
            FETCHER_FETCHING: begin
                if (beat_ok && last_beat)
                    state_d = FETCHER_FETCHED;
            end
            FETCHER_FETCHED: begin
                if (core_state == CORE_DECODE)
                    state_d = FETCHER_IDLE;
            end
            default: state_d = FETCHER_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        req_d        = req_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        shadow_d     = shadow_q;
        hit_d        = 1'b0;
        valid_d      = valid_q;
        tag_d        = tag_q;
        pend_tag_d   = pend_tag_q;
        cnt_d        = cnt_q;
        flush_seen_d = flush_seen_q;

        if (flush)
            valid_d = 1'b0;

        case (state_q)
            FETCHER_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (is_hit) begin
                        // instruction register already holds the buffered word
                        hit_d = 1'b1;
                    end else begin
                        req_d        = 1'b1;
                        addr_d       = MEM_ADDR_WIDTH'(current_pc) * MEM_ADDR_WIDTH'(BEATS);
                        cnt_d        = '0;
                        pend_tag_d   = current_pc;
                        flush_seen_d = 1'b0;
                    end
                end
            end
            FETCHER_FETCHING: begin
                if (flush)
                    flush_seen_d = 1'b1;
                if (beat_ok) begin
                    if (last_beat) begin
                        instr_d = full_word;
                        req_d   = 1'b0;
                        tag_d   = pend_tag_q;
                        valid_d = !(flush_seen_q || flush);
                    end else begin
                        shadow_d = full_word;
                        cnt_d    = cnt_q + CNT_W'(1);
                        addr_d   = addr_q + MEM_ADDR_WIDTH'(1);
                    end
                end
            end
            FETCHER_FETCHED: ;
            default: req_d = 1'b0;
        endcase
    end

    assign mem.mem_read_request = req_q;
    assign mem.mem_read_address = addr_q;
    assign fetcher_state        = state_q;
    assign instruction          = instr_q;
    assign fetch_hit            = hit_q;
endmodule
